// File: rtl/sram_dp_be.sv
// Dual-port byte-enabled SRAM with power-up/on-demand clear sequencer.
// One write port and one registered read port share a single clock.
module sram_dp_be #(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRESSWIDTH = 8,
    parameter int BYTEWIDTH    = 8,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    input  logic                    we,
    input  logic [ADDRESSWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0] wr_be,
    input  logic [DATAWIDTH-1:0]    data_in,
    input  logic                    re,
    input  logic [ADDRESSWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0]    data_out,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int DEPTH  = 2 ** ADDRESSWIDTH;
    localparam int NBYTES = DATAWIDTH / BYTEWIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDRESSWIDTH-1:0] cnt;
    logic [ADDRESSWIDTH-1:0] cnt_nxt;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] wr_merged;
    logic [DATAWIDTH-1:0] rd_word;
    logic                 wr_go;
    logic                 rd_go;

    assign busy  = (state == CLEAR);
    assign wr_go = (state == READY) && we;
    assign rd_go = (state == READY) && re;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            CLEAR: begin
                if (cnt == '1) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Merged word also feeds the write-first bypass on a same-address read.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
                wr_merged[i*BYTEWIDTH +: BYTEWIDTH] =
                    data_in[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
        if ((WRITE_FIRST != 0) && wr_go && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    // Storage has no reset; contents are zeroed by the CLEAR walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_go) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                data_out <= rd_word;
            end
        end
    end

endmodule
